// File: rtl/sdram_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sdram_pkg: SDRAM command words, field positions, arbiter states  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package sdram_pkg;

    localparam int C_CMD_W = 18;

    // Word layout: {cs_n, ras_n, cas_n, we_n, ba[1:0], addr[11:0]}
    localparam logic [C_CMD_W-1:0] C_NOP_CMD = 18'h1c000;
    localparam logic [C_CMD_W-1:0] C_PRE_CMD = 18'h08400;  // addr[10]=1: all banks
    localparam logic [C_CMD_W-1:0] C_REF_CMD = 18'h04000;
    localparam logic [C_CMD_W-1:0] C_MRS_CMD = 18'h00000;
    localparam logic [C_CMD_W-1:0] C_ACT_CMD = 18'h0c000;
    localparam logic [C_CMD_W-1:0] C_WR_CMD  = 18'h10000;
    localparam logic [C_CMD_W-1:0] C_RD_CMD  = 18'h14000;

    localparam int C_CS_N_BIT  = 17;
    localparam int C_RAS_N_BIT = 16;
    localparam int C_CAS_N_BIT = 15;
    localparam int C_WE_N_BIT  = 14;
    localparam int C_BA_HI     = 13;
    localparam int C_BA_LO     = 12;
    localparam int C_ADDR_HI   = 11;
    localparam int C_ADDR_LO   = 0;

    localparam logic [2:0] C_ST_INIT  = 3'd0;
    localparam logic [2:0] C_ST_ARBIT = 3'd1;
    localparam logic [2:0] C_ST_AREF  = 3'd2;
    localparam logic [2:0] C_ST_WRITE = 3'd3;
    localparam logic [2:0] C_ST_READ  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/sdram_arbit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sdram_arbit: fixed-priority owner arbiter and SDRAM pin register |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int                CMD_W   = C_CMD_W,
    parameter logic [CMD_W-1:0]  NOP_CMD = C_NOP_CMD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CMD_W-1:0] init_cmd,
    input  logic             ini_end,
    input  logic             ref_req,
    input  logic             wr_req,
    input  logic             rd_req,
    input  logic             ref_end,
    input  logic             wr_end,
    input  logic             rd_end,
    input  logic [CMD_W-1:0] ref_cmd,
    input  logic [CMD_W-1:0] wr_cmd,
    input  logic [CMD_W-1:0] rd_cmd,
    output logic             ref_en,
    output logic             wr_en,
    output logic             rd_en,
    output logic             sdram_cke,
    output logic             sdram_cs_n,
    output logic             sdram_ras_n,
    output logic             sdram_cas_n,
    output logic             sdram_we_n,
    output logic [1:0]       sdram_ba,
    output logic [11:0]      sdram_addr
);

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [CMD_W-1:0] cmd_q;
    logic [CMD_W-1:0] cmd_d;
    logic             cke_q;

    // Owners always fall back to ARBIT on their own end; other ends are ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_INIT: begin
                if (ini_end) state_d = C_ST_ARBIT;
            end
            C_ST_ARBIT: begin
                if (ref_req)     state_d = C_ST_AREF;
                else if (wr_req) state_d = C_ST_WRITE;
                else if (rd_req) state_d = C_ST_READ;
            end
            C_ST_AREF: begin
                if (ref_end) state_d = C_ST_ARBIT;
            end
            C_ST_WRITE: begin
                if (wr_end) state_d = C_ST_ARBIT;
            end
            C_ST_READ: begin
                if (rd_end) state_d = C_ST_ARBIT;
            end
            default: state_d = C_ST_INIT;
        endcase
    end

    always_comb begin
        cmd_d = NOP_CMD;
        case (state_q)
            C_ST_INIT:  cmd_d = init_cmd;
            C_ST_AREF:  cmd_d = ref_cmd;
            C_ST_WRITE: cmd_d = wr_cmd;
            C_ST_READ:  cmd_d = rd_cmd;
            default:    cmd_d = NOP_CMD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= C_ST_INIT;
            cmd_q   <= NOP_CMD;
            cke_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            cke_q   <= 1'b1;
        end
    end

    assign ref_en      = (state_q == C_ST_AREF);
    assign wr_en       = (state_q == C_ST_WRITE);
    assign rd_en       = (state_q == C_ST_READ);

    assign sdram_cke   = cke_q;
    assign sdram_cs_n  = cmd_q[C_CS_N_BIT];
    assign sdram_ras_n = cmd_q[C_RAS_N_BIT];
    assign sdram_cas_n = cmd_q[C_CAS_N_BIT];
    assign sdram_we_n  = cmd_q[C_WE_N_BIT];
    assign sdram_ba    = cmd_q[C_BA_HI:C_BA_LO];
    assign sdram_addr  = cmd_q[C_ADDR_HI:C_ADDR_LO];

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_sdram_arbit: directed scoreboard bench for sdram_arbit        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_sdram_arbit;

    localparam logic [17:0] NOP  = 18'h1c000;
    localparam logic [17:0] REFC = 18'h04000;
    localparam logic [17:0] INIC = 18'h04000;
    localparam logic [17:0] WRC  = 18'h10123;
    localparam logic [17:0] RDC  = 18'h15045;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] init_cmd, ref_cmd, wr_cmd, rd_cmd;
    logic        ini_end, ref_req, wr_req, rd_req, ref_end, wr_end, rd_end;
    logic        ref_en, wr_en, rd_en, sdram_cke;
    logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [11:0] sdram_addr;

    typedef struct {
        string       tag;
        logic [21:0] val;   // {cke, ref_en, wr_en, rd_en, pins[17:0]}
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    sdram_arbit dut (
        .clk        (clk),
        .rst        (rst),
        .init_cmd   (init_cmd),
        .ini_end    (ini_end),
        .ref_req    (ref_req),
        .wr_req     (wr_req),
        .rd_req     (rd_req),
        .ref_end    (ref_end),
        .wr_end     (wr_end),
        .rd_end     (rd_end),
        .ref_cmd    (ref_cmd),
        .wr_cmd     (wr_cmd),
        .rd_cmd     (rd_cmd),
        .ref_en     (ref_en),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .sdram_cke  (sdram_cke),
        .sdram_cs_n (sdram_cs_n),
        .sdram_ras_n(sdram_ras_n),
        .sdram_cas_n(sdram_cas_n),
        .sdram_we_n (sdram_we_n),
        .sdram_ba   (sdram_ba),
        .sdram_addr (sdram_addr)
    );

    // Expected grants (ref,wr,rd) and pin word after the next rising edge.
    task automatic expect_next(input string tag, input logic [2:0] en, input logic [17:0] pins);
        exp_t e;
        e.tag = tag;
        e.val = {1'b1, en, pins};
        q.push_back(e);
    endtask

    task automatic tick();
        logic [21:0] obs;
        exp_t        e;
        @(posedge clk);
        #1;
        obs = {sdram_cke, ref_en, wr_en, rd_en,
               sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr};
        while (q.size() > 0) begin
            e = q.pop_front();
            total++;
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    initial begin
        rst = 1'b1; init_cmd = INIC; ini_end = 1'b0;
        ref_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        ref_end = 1'b0; wr_end = 1'b0; rd_end = 1'b0;
        ref_cmd = NOP; wr_cmd = WRC; rd_cmd = RDC;
        tick();
        expect_next("reset", 3'b000, NOP); tick();

        // Init pass-through; a request in INIT must be held off
        rst = 1'b0; ref_req = 1'b1;
        expect_next("init_pass", 3'b000, INIC); tick();
        expect_next("init_hold", 3'b000, INIC); tick();
        ref_req = 1'b0; ini_end = 1'b1;
        expect_next("init_end", 3'b000, INIC); tick();
        expect_next("arbit_nop", 3'b000, NOP); tick();

        // Refresh handshake
        ref_req = 1'b1;
        expect_next("ref_grant", 3'b100, NOP); tick();
        ref_req = 1'b0; ref_cmd = REFC;
        expect_next("ref_pins", 3'b100, REFC); tick();
        ref_cmd = NOP; rd_end = 1'b1;
        expect_next("stray_rd_end", 3'b100, NOP); tick();
        rd_end = 1'b0;
        expect_next("ref_hold", 3'b100, NOP); tick();
        ref_end = 1'b1;
        expect_next("ref_release", 3'b000, NOP); tick();
        ref_end = 1'b0;
        expect_next("ref_idle", 3'b000, NOP); tick();

        // Priority: all three at once
        ref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        expect_next("prio_ref", 3'b100, NOP); tick();
        ref_req = 1'b0; ref_cmd = REFC;
        expect_next("prio_ref_cmd", 3'b100, REFC); tick();
        ref_cmd = NOP; ref_end = 1'b1;
        expect_next("prio_ref_end", 3'b000, NOP); tick();
        ref_end = 1'b0;
        expect_next("prio_wr", 3'b010, NOP); tick();

        // No preemption of the write by a new refresh request
        wr_req = 1'b0; ref_req = 1'b1;
        expect_next("wr_cmd1", 3'b010, WRC); tick();
        expect_next("wr_cmd2", 3'b010, WRC); tick();
        wr_end = 1'b1;
        expect_next("wr_release", 3'b000, WRC); tick();
        wr_end = 1'b0;
        expect_next("ref_after_wr", 3'b100, NOP); tick();
        ref_req = 1'b0; ref_end = 1'b1;
        expect_next("ref_end2", 3'b000, NOP); tick();
        ref_end = 1'b0;
        expect_next("prio_rd", 3'b001, NOP); tick();
        rd_req = 1'b0;
        expect_next("rd_cmd", 3'b001, RDC); tick();

        // End and new request in the same cycle: ARBIT first
        rd_end = 1'b1; wr_req = 1'b1;
        expect_next("rd_end_req", 3'b000, RDC); tick();
        rd_end = 1'b0;
        expect_next("wr_after_rd", 3'b010, NOP); tick();
        wr_req = 1'b0;
        expect_next("wr_active", 3'b010, WRC); tick();

        // Reset mid-write, then ini_end must be re-seen
        rst = 1'b1;
        expect_next("rst_mid_wr", 3'b000, NOP); tick();
        rst = 1'b0; ini_end = 1'b0; wr_req = 1'b1;
        expect_next("post_rst_init", 3'b000, INIC); tick();
        expect_next("post_rst_hold", 3'b000, INIC); tick();
        ini_end = 1'b1;
        expect_next("post_rst_end", 3'b000, INIC); tick();
        expect_next("post_rst_wr", 3'b010, NOP); tick();
        wr_req = 1'b0;
        expect_next("post_rst_wrcmd", 3'b010, WRC); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
